// File: rtl/mutative_types_pkg.sv
// Shared types for the mutative cache: address layout, geometry constants and way-mode encoding.
package mutative_types;

  localparam int SET_BITS    = 4;
  localparam int TAG_BITS    = 23;
  localparam int OFFSET_BITS = 32 - SET_BITS - TAG_BITS;
  localparam int WAYS        = 8;

  typedef struct packed {
    logic [TAG_BITS-1:0]    tag;
    logic [SET_BITS-1:0]    set_index;
    logic [OFFSET_BITS-1:0] offset;
  } cache_address_t;

  typedef enum logic [1:0] {
    MODE_DM   = 2'd0,
    MODE_2WAY = 2'd1,
    MODE_4WAY = 2'd2,
    MODE_8WAY = 2'd3
  } mode_t;

endpackage

// File: rtl/assoc_shadow_tags.sv
// Shadow tag table: one {valid, tag} entry per set, used to spot set conflicts between accesses.
module assoc_shadow_tags
  import mutative_types::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                write_en,
  input  logic                invalidate_all,
  input  logic [SET_BITS-1:0] set_index,
  input  logic [TAG_BITS-1:0] tag,
  output logic                conflict
);

  localparam int SETS = 1 << SET_BITS;

  logic [SETS-1:0]     valid_q;
  logic [TAG_BITS-1:0] tag_q [SETS];

  assign conflict = valid_q[set_index] && (tag_q[set_index] != tag);

  // NOTE: reset is sampled on the clock edge, so it lives inside the clocked block, not the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (invalidate_all) begin
      valid_q <= '0;
    end else if (write_en) begin
      valid_q[set_index] <= 1'b1;
    end
  end

  // NOTE: tag storage is intentionally not reset; the valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (write_en) begin
      tag_q[set_index] <= tag;
    end
  end

endmodule

// File: rtl/associativity_governor.sv
// Watches completed accesses, estimates conflict pressure per epoch and requests a way-mode step.
module associativity_governor
  import mutative_types::*;
#(
  parameter int EPOCH_LEN  = 256,
  parameter int HI_THRESH  = 64,
  parameter int LO_THRESH  = 16,
  parameter int SKEW_LIMIT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cache_address,
  input  logic        cpu_request,
  input  logic        cache_ready,
  input  logic        setup_ready,
  input  logic        plru_bit0,
  input  logic        tie,
  output logic [1:0]  setup,
  output logic        setup_valid,
  output logic        setup_update
);

  localparam int CNT_W = $clog2(EPOCH_LEN) + 1;
  localparam int BAL_W = CNT_W + 1;

  localparam logic STATE_MONITOR = 1'b0;
  localparam logic STATE_REQUEST = 1'b1;

  localparam logic [1:0]              MODE_TOP   = 2'($clog2(WAYS));
  localparam logic [CNT_W-1:0]        EPOCH_LAST = CNT_W'(EPOCH_LEN - 1);
  localparam logic [CNT_W-1:0]        HI_CNT     = CNT_W'(HI_THRESH);
  localparam logic [CNT_W-1:0]        LO_CNT     = CNT_W'(LO_THRESH);
  localparam logic signed [BAL_W-1:0] SKEW_LIM   = BAL_W'(SKEW_LIMIT);
  // Symmetric saturation keeps the magnitude of the balance representable.
  localparam logic signed [BAL_W-1:0] BAL_MAX    = {1'b0, {(BAL_W-1){1'b1}}};

  cache_address_t addr;
  logic           unused_offset;

  logic                    state_q;
  logic                    eval_pending_q;
  logic [1:0]              setup_q;
  logic [1:0]              target_q;
  logic                    setup_valid_q;
  logic [CNT_W-1:0]        epoch_q,   epoch_d;
  logic [CNT_W-1:0]        conflict_q, conflict_d;
  logic signed [BAL_W-1:0] balance_q, balance_d, balance_abs;
  logic [1:0]              next_target;
  logic                    event_hit;
  logic                    handshake;
  logic                    conflict;

  assign addr          = cache_address;
  assign unused_offset = ^addr.offset;

  assign event_hit = cpu_request && cache_ready && (state_q == STATE_MONITOR);
  assign handshake = (state_q == STATE_REQUEST) && setup_ready;

  assoc_shadow_tags u_shadow (
    .clk            (clk),
    .rst            (rst),
    .write_en       (event_hit),
    .invalidate_all (handshake),
    .set_index      (addr.set_index),
    .tag            (addr.tag),
    .conflict       (conflict)
  );

  // Counters restart at the evaluation cycle; an event landing there opens the next epoch.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    epoch_d    = eval_pending_q ? '0 : epoch_q;
    conflict_d = eval_pending_q ? '0 : conflict_q;
    balance_d  = eval_pending_q ? '0 : balance_q;
    if (event_hit) begin
      epoch_d = epoch_d + CNT_W'(1);
      if (conflict && conflict_d != '1) begin
        conflict_d = conflict_d + CNT_W'(1);
      end
      if (!tie) begin
        if (plru_bit0 && balance_d != BAL_MAX) begin
          balance_d = balance_d + BAL_W'(1);
        end else if (!plru_bit0 && balance_d != -BAL_MAX) begin
          balance_d = balance_d - BAL_W'(1);
        end
      end
    end
  end

  always_comb begin
    balance_abs = balance_q[BAL_W-1] ? -balance_q : balance_q;
    next_target = setup_q;
    if (conflict_q >= HI_CNT && setup_q != MODE_TOP) begin
      next_target = setup_q + 2'd1;
    end else if (conflict_q < LO_CNT && setup_q != MODE_DM && balance_abs <= SKEW_LIM) begin
      next_target = setup_q - 2'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      epoch_q        <= '0;
      conflict_q     <= '0;
      balance_q      <= '0;
      eval_pending_q <= 1'b0;
    end else begin
      epoch_q        <= epoch_d;
      conflict_q     <= conflict_d;
      balance_q      <= balance_d;
      eval_pending_q <= event_hit && (epoch_d == EPOCH_LAST + CNT_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= STATE_MONITOR;
      setup_q       <= MODE_8WAY;
      target_q      <= MODE_8WAY;
      setup_valid_q <= 1'b0;
    end else begin
      case (state_q)
        STATE_MONITOR: begin
          if (eval_pending_q && next_target != setup_q) begin
            target_q      <= next_target;
            setup_valid_q <= 1'b1;
            state_q       <= STATE_REQUEST;
          end
        end
        default: begin
          if (setup_ready) begin
            setup_q       <= target_q;
            setup_valid_q <= 1'b0;
            state_q       <= STATE_MONITOR;
          end
        end
      endcase
    end
  end

  assign setup        = setup_q;
  assign setup_valid  = setup_valid_q;
  assign setup_update = handshake;

endmodule

// File: tb/tb_associativity_governor.sv
// Directed bench for associativity_governor: epoch evaluation, handshake, skew blocking, reset abort.
module tb_associativity_governor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] cache_address = '0;
  logic        cpu_request = 1'b0;
  logic        cache_ready = 1'b0;
  logic        setup_ready = 1'b0;
  logic        plru_bit0 = 1'b0;
  logic        tie = 1'b0;
  logic [1:0]  setup;
  logic        setup_valid;
  logic        setup_update;

  int n_compared   = 0;
  int n_mismatched = 0;

  associativity_governor dut (
    .clk           (clk),
    .rst           (rst),
    .cache_address (cache_address),
    .cpu_request   (cpu_request),
    .cache_ready   (cache_ready),
    .setup_ready   (setup_ready),
    .plru_bit0     (plru_bit0),
    .tie           (tie),
    .setup         (setup),
    .setup_valid   (setup_valid),
    .setup_update  (setup_update)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One completed access for one cycle.
  task automatic do_event(input logic [3:0] set_i, input logic [22:0] tag_i,
                          input logic plru_i, input logic tie_i);
    cache_address = {tag_i, set_i, 5'd0};
    plru_bit0     = plru_i;
    tie           = tie_i;
    cpu_request   = 1'b1;
    cache_ready   = 1'b1;
    tick();
    cpu_request   = 1'b0;
    cache_ready   = 1'b0;
  endtask

  // Called right after the epoch-closing event: one evaluation cycle, then the decision is visible.
  task automatic epoch_done(input string tag, input logic exp_valid, input logic [1:0] exp_setup);
    @(negedge clk);
    check({tag, "_eval_cycle_valid"}, setup_valid, 1'b0);
    @(negedge clk);
    check({tag, "_valid"}, setup_valid, exp_valid);
    check({tag, "_setup"}, setup, exp_setup);
    check({tag, "_update"}, setup_update, 1'b0);
  endtask

  task automatic handshake(input string tag, input logic [1:0] exp_old, input logic [1:0] exp_new);
    repeat (5) tick();
    @(negedge clk);
    check({tag, "_hold_valid"}, setup_valid, 1'b1);
    check({tag, "_hold_setup"}, setup, exp_old);
    check({tag, "_hold_update"}, setup_update, 1'b0);
    setup_ready = 1'b1;
    #1;
    check({tag, "_update_pulse"}, setup_update, 1'b1);
    tick();
    setup_ready = 1'b0;
    @(negedge clk);
    check({tag, "_new_setup"}, setup, exp_new);
    check({tag, "_valid_drop"}, setup_valid, 1'b0);
    check({tag, "_update_low"}, setup_update, 1'b0);
  endtask

  initial begin
    // Reset held for two edges.
    rst = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("reset_setup", setup, 2'd3);
    check("reset_valid", setup_valid, 1'b0);
    check("reset_update", setup_update, 1'b0);
    tick();
    rst = 1'b1;

    // Heavy conflicts on set 0 while already 8-way: no request.
    for (int i = 0; i < 256; i++) do_event(4'd0, (i % 2 == 1) ? 23'h2 : 23'h1, i[0], 1'b0);
    epoch_done("hi_at_top", 1'b0, 2'd3);
    setup_ready = 1'b1;
    tick();
    setup_ready = 1'b0;
    @(negedge clk);
    check("ready_in_monitor_ignored", setup, 2'd3);

    // Same tag everywhere, balanced PLRU: zero conflicts, lower to 4-way.
    for (int i = 0; i < 256; i++) do_event(4'(i % 16), 23'h2, i[0], 1'b0);
    epoch_done("lower_3", 1'b1, 2'd3);
    handshake("hs_3to2", 2'd3, 2'd2);

    // Zero conflicts but PLRU always right: balance 256 blocks lowering.
    for (int i = 0; i < 256; i++) do_event(4'd3, 23'h9, 1'b1, 1'b0);
    epoch_done("skew_block", 1'b0, 2'd2);

    // Ties leave the balance at zero: lower twice down to direct-mapped.
    for (int i = 0; i < 256; i++) do_event(4'd3, 23'h9, 1'b0, 1'b1);
    epoch_done("lower_2", 1'b1, 2'd2);
    handshake("hs_2to1", 2'd2, 2'd1);
    for (int i = 0; i < 256; i++) do_event(4'd3, 23'h9, 1'b0, 1'b1);
    epoch_done("lower_1", 1'b1, 2'd1);
    handshake("hs_1to0", 2'd1, 2'd0);

    // 100 tag changes on set 0 from DM: raise to 2-way.
    for (int i = 0; i < 256; i++)
      do_event(4'd0, (i >= 1 && i <= 100 && i % 2 == 1) ? 23'h7 : 23'h6, 1'b0, 1'b1);
    epoch_done("raise_0", 1'b1, 2'd0);
    // Conflicting, skewed traffic during REQUEST must be ignored.
    for (int i = 0; i < 20; i++) do_event(4'd1, (i % 2 == 1) ? 23'hA : 23'hB, 1'b1, 1'b0);
    handshake("hs_0to1", 2'd0, 2'd1);

    // A clean epoch lowers again only once all 256 fresh events arrive.
    for (int i = 0; i < 236; i++) do_event(4'd5, 23'h4, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("no_early_epoch", setup_valid, 1'b0);
    for (int i = 0; i < 20; i++) do_event(4'd5, 23'h4, 1'b0, 1'b1);
    epoch_done("lower_after_req", 1'b1, 2'd1);
    handshake("hs_1to0_b", 2'd1, 2'd0);

    // Fill all sets with tag 0x20 under heavy conflicts, then abort the raise with reset.
    for (int i = 0; i < 256; i++)
      do_event(4'(i % 16), (i >= 240) ? 23'h20 : (((i / 16) % 2 == 1) ? 23'h11 : 23'h10), 1'b0, 1'b1);
    epoch_done("raise_fill", 1'b1, 2'd0);
    rst = 1'b0;
    tick();
    @(negedge clk);
    check("abort_setup", setup, 2'd3);
    check("abort_valid", setup_valid, 1'b0);
    check("abort_update", setup_update, 1'b0);
    tick();
    rst = 1'b1;

    // Table must be empty after reset: new tag on every set gives no conflicts, so lower.
    for (int i = 0; i < 256; i++) do_event(4'(i % 16), 23'h30, i[0], 1'b0);
    epoch_done("table_cleared", 1'b1, 2'd3);
    handshake("hs_post_reset", 2'd3, 2'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
